// File: rtl/barrier_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : barrier_scheduler_if
//  Description : Control/status bundle between the game controller and the
//                barrier scheduler (player inputs, divider pause, slot pool).
//  Revision    : 1.0 - initial release
// ============================================================================
interface barrier_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                     start;
    logic                     pause;
    logic                     collide;
    logic                     scroll_tick;
    logic                     div_pause;
    logic [1:0]               state;
    logic [NUM_SLOTS-1:0]     slot_valid;
    logic [4*NUM_SLOTS-1:0]   slot_col;
    logic [4*NUM_SLOTS-1:0]   slot_gap;
    logic [7:0]               score;
    logic                     game_over;

    // Controller side: drives the player/timing inputs, observes the pool
    modport master (
        output start, pause, collide, scroll_tick,
        input  div_pause, state, slot_valid, slot_col, slot_gap, score, game_over
    );

    // Scheduler side
    modport slave (
        input  start, pause, collide, scroll_tick,
        output div_pause, state, slot_valid, slot_col, slot_gap, score, game_over
    );
endinterface
`default_nettype wire

// File: rtl/barrier_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : barrier_scheduler
//  Description : Game-level FSM (idle/run/paused/over) plus a pool of barrier
//                slots that spawn from an LFSR, scroll left on each accepted
//                scroll tick, retire at column 0 and feed a saturating score.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrier_scheduler #(
    parameter int NUM_SLOTS    = 4,
    parameter int COLS         = 16,
    parameter int ROWS         = 16,
    parameter int GAP_H        = 4,
    parameter int SPAWN_PERIOD = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    barrier_scheduler_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_PAUSED = 2'b10;
    localparam logic [1:0] c_ST_OVER   = 2'b11;

    localparam int              c_CNT_W     = $clog2(SPAWN_PERIOD);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SPAWN_PERIOD - 1);
    localparam int              c_IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [3:0]      c_SPAWN_COL = 4'(COLS - 1);
    localparam logic [3:0]      c_GAP_MAX   = 4'(ROWS - GAP_H);
    localparam logic [3:0]      c_GAP_H     = 4'(GAP_H);
    localparam logic [7:0]      c_LFSR_SEED = 8'hA5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_div_pause;
    logic                  r_game_over;
    logic [7:0]            r_lfsr;
    logic [NUM_SLOTS-1:0]  r_valid;
    logic [3:0]            r_col [NUM_SLOTS];
    logic [3:0]            r_gap [NUM_SLOTS];
    logic [7:0]            r_score;
    logic [c_CNT_W-1:0]    r_spawn_cnt;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [1:0]            w_state_next;
    logic                  w_div_pause_next;
    logic                  w_game_over_next;
    logic                  w_tick_acc;
    logic                  w_clear;
    logic                  w_free_found;
    logic [c_IDX_W-1:0]    w_free_idx;
    logic [3:0]            w_retire_cnt;
    logic [8:0]            w_score_sum;
    logic [7:0]            w_score_next;
    logic [3:0]            w_gap_raw;
    logic [3:0]            w_gap;
    logic                  w_spawn;
    logic                  w_lfsr_fb;

    // A tick only counts while running and not in the same cycle as a hit
    assign w_tick_acc = (r_state == c_ST_RUN) && bus.scroll_tick && !bus.collide;
    // Entering a new game (IDLE->RUN) or acknowledging game over (OVER->IDLE)
    assign w_clear    = ((r_state == c_ST_IDLE) || (r_state == c_ST_OVER)) && bus.start;

    // State register; divider pause and game_over are registered alongside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_div_pause <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_div_pause <= w_div_pause_next;
            r_game_over <= w_game_over_next;
        end
    end

    // Next-state logic, priority top-down within each state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (bus.start)    w_state_next = c_ST_RUN;
            c_ST_RUN: begin
                if (bus.collide)           w_state_next = c_ST_OVER;
                else if (bus.pause)        w_state_next = c_ST_PAUSED;
            end
            c_ST_PAUSED: if (!bus.pause)   w_state_next = c_ST_RUN;
            c_ST_OVER:   if (bus.start)    w_state_next = c_ST_IDLE;
            default:                       w_state_next = c_ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flags track r_state exactly
    always_comb begin
        w_div_pause_next = (w_state_next != c_ST_RUN);
        w_game_over_next = (w_state_next == c_ST_OVER);
    end

    // Free-running LFSR, x^8+x^6+x^5+x^4+1, steps in every state
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= c_LFSR_SEED;
        else        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end

    // Lowest-index slot free before this tick; retiring slots are not candidates
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    // Count slots leaving the playfield on this tick and saturate the score
    always_comb begin
        w_retire_cnt = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_valid[i] && (r_col[i] == 4'd0)) w_retire_cnt = w_retire_cnt + 4'd1;
        end
        w_score_sum  = {1'b0, r_score} + {5'd0, w_retire_cnt};
        w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
    end

    // Gap choice folds out-of-range LFSR values back into the legal range
    assign w_gap_raw = r_lfsr[3:0];
    assign w_gap     = (w_gap_raw <= c_GAP_MAX) ? w_gap_raw : (w_gap_raw - c_GAP_H);
    assign w_spawn   = w_tick_acc && (r_spawn_cnt == c_CNT_LAST) && w_free_found;

    // Slot pool, score and spawn counter: cleared on game boundaries, else tick-driven
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_score     <= 8'd0;
            r_spawn_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_col[i] <= 4'd0;
                r_gap[i] <= 4'd0;
            end
        end else if (w_clear) begin
            r_valid     <= '0;
            r_score     <= 8'd0;
            r_spawn_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_col[i] <= 4'd0;
                r_gap[i] <= 4'd0;
            end
        end else if (w_tick_acc) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_valid[i]) begin
                    if (r_col[i] == 4'd0) r_valid[i] <= 1'b0;
                    else                  r_col[i]   <= r_col[i] - 4'd1;
                end
            end
            if (w_spawn) begin
                r_valid[w_free_idx] <= 1'b1;
                r_col[w_free_idx]   <= c_SPAWN_COL;
                r_gap[w_free_idx]   <= w_gap;
            end
            r_score     <= w_score_next;
            r_spawn_cnt <= (r_spawn_cnt == c_CNT_LAST) ? '0 : (r_spawn_cnt + 1'b1);
        end
    end

    // Flatten slot arrays onto the bus
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pack
        assign bus.slot_col[4*gi +: 4] = r_col[gi];
        assign bus.slot_gap[4*gi +: 4] = r_gap[gi];
    end

    assign bus.state      = r_state;
    assign bus.div_pause  = r_div_pause;
    assign bus.game_over  = r_game_over;
    assign bus.slot_valid = r_valid;
    assign bus.score      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_barrier_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrier_scheduler
//  Description : Directed self-checking bench for barrier_scheduler; a default
//                instance (4 slots, period 6) and a small one (2 slots, period 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrier_scheduler;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    barrier_scheduler_if #(.NUM_SLOTS(4)) ba ();
    barrier_scheduler_if #(.NUM_SLOTS(2)) bb ();

    barrier_scheduler #(.NUM_SLOTS(4), .COLS(16), .ROWS(16), .GAP_H(4), .SPAWN_PERIOD(6))
        u_dut_a (.clk(clk), .reset(reset), .bus(ba));
    barrier_scheduler #(.NUM_SLOTS(2), .COLS(16), .ROWS(16), .GAP_H(4), .SPAWN_PERIOD(2))
        u_dut_b (.clk(clk), .reset(reset), .bus(bb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted-tick slot on instance A, ticks spaced 5 clocks apart
    task automatic tick_a();
        @(negedge clk) ba.scroll_tick = 1'b1;
        @(negedge clk) ba.scroll_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ba.state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", ba.state); end
        n_checks++; if (ba.div_pause !== 1'b1) begin n_fail++; $display("FAIL reset_div_pause got %b exp 1", ba.div_pause); end
        n_checks++; if (ba.slot_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b exp 0000", ba.slot_valid); end
        n_checks++; if (ba.score !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", ba.score); end
        n_checks++; if (ba.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over got %b exp 0", ba.game_over); end
        n_checks++; if (ba.slot_col !== 16'h0000 || ba.slot_gap !== 16'h0000) begin n_fail++; $display("FAIL reset_cols col %h gap %h exp 0000", ba.slot_col, ba.slot_gap); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (ba.state !== 2'b00) begin n_fail++; $display("FAIL idle_hold got %b exp 00", ba.state); end
    endtask

    task automatic test_start();
        @(negedge clk) ba.start = 1'b1;
        @(negedge clk) ba.start = 1'b0;
        n_checks++; if (ba.state !== 2'b01) begin n_fail++; $display("FAIL start_state got %b exp 01", ba.state); end
        n_checks++; if (ba.div_pause !== 1'b0) begin n_fail++; $display("FAIL start_div_pause got %b exp 0", ba.div_pause); end
    endtask

    task automatic test_first_spawn();
        for (int k = 1; k <= 5; k++) tick_a();
        n_checks++; if (ba.slot_valid !== 4'b0000) begin n_fail++; $display("FAIL no_spawn_tick5 got %b exp 0000", ba.slot_valid); end
        tick_a();
        n_checks++; if (ba.slot_valid !== 4'b0001) begin n_fail++; $display("FAIL spawn_tick6_valid got %b exp 0001", ba.slot_valid); end
        n_checks++; if (ba.slot_col[3:0] !== 4'd15) begin n_fail++; $display("FAIL spawn_tick6_col got %0d exp 15", ba.slot_col[3:0]); end
        n_checks++; if (!(ba.slot_gap[3:0] <= 4'd12)) begin n_fail++; $display("FAIL spawn_tick6_gap got %0d exp <=12", ba.slot_gap[3:0]); end
    endtask

    task automatic test_scroll_retire();
        for (int k = 7; k <= 24; k++) begin
            tick_a();
            if (k == 12) begin
                n_checks++; if (ba.slot_valid !== 4'b0011 || ba.slot_col[7:4] !== 4'd15) begin n_fail++; $display("FAIL tick12 valid %b col1 %0d exp 0011/15", ba.slot_valid, ba.slot_col[7:4]); end
            end
            if (k == 18) begin
                n_checks++; if (ba.slot_valid !== 4'b0111 || ba.slot_col[11:8] !== 4'd15) begin n_fail++; $display("FAIL tick18 valid %b col2 %0d exp 0111/15", ba.slot_valid, ba.slot_col[11:8]); end
            end
            if (k == 21) begin
                n_checks++; if (ba.slot_col[3:0] !== 4'd0 || ba.slot_valid[0] !== 1'b1) begin n_fail++; $display("FAIL tick21 col0 %0d valid0 %b exp 0/1", ba.slot_col[3:0], ba.slot_valid[0]); end
                n_checks++; if (ba.score !== 8'd0) begin n_fail++; $display("FAIL tick21_score got %0d exp 0", ba.score); end
            end
            if (k == 22) begin
                n_checks++; if (ba.slot_valid !== 4'b0110) begin n_fail++; $display("FAIL tick22_valid got %b exp 0110", ba.slot_valid); end
                n_checks++; if (ba.score !== 8'd1) begin n_fail++; $display("FAIL tick22_score got %0d exp 1", ba.score); end
            end
            if (k == 23) begin
                n_checks++; if (ba.slot_valid !== 4'b0110) begin n_fail++; $display("FAIL tick23_valid got %b exp 0110", ba.slot_valid); end
            end
        end
        n_checks++; if (ba.slot_valid !== 4'b0111) begin n_fail++; $display("FAIL tick24_valid got %b exp 0111", ba.slot_valid); end
        n_checks++; if (ba.slot_col[11:0] !== 12'h93F) begin n_fail++; $display("FAIL tick24_cols got %h exp 93f", ba.slot_col[11:0]); end
    endtask

    task automatic test_pause();
        logic [15:0] col_s, gap_s;
        logic [3:0]  val_s;
        logic [7:0]  sc_s;
        col_s = ba.slot_col; gap_s = ba.slot_gap; val_s = ba.slot_valid; sc_s = ba.score;
        @(negedge clk) ba.pause = 1'b1;
        @(negedge clk);
        n_checks++; if (ba.state !== 2'b10 || ba.div_pause !== 1'b1) begin n_fail++; $display("FAIL pause_enter state %b div %b exp 10/1", ba.state, ba.div_pause); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ba.scroll_tick = (c % 2 == 0);
            ba.collide     = (c == 5);
        end
        @(negedge clk) begin ba.scroll_tick = 1'b0; ba.collide = 1'b0; end
        n_checks++; if (ba.state !== 2'b10) begin n_fail++; $display("FAIL pause_collide_ignored got %b exp 10", ba.state); end
        n_checks++; if (ba.slot_col !== col_s || ba.slot_gap !== gap_s || ba.slot_valid !== val_s || ba.score !== sc_s) begin n_fail++; $display("FAIL pause_hold col %h gap %h val %b sc %0d", ba.slot_col, ba.slot_gap, ba.slot_valid, ba.score); end
        ba.pause = 1'b0;
        @(negedge clk);
        n_checks++; if (ba.state !== 2'b01 || ba.div_pause !== 1'b0) begin n_fail++; $display("FAIL pause_exit state %b div %b exp 01/0", ba.state, ba.div_pause); end
        tick_a();
        n_checks++; if (ba.slot_col[11:0] !== 12'h82E || ba.slot_valid !== 4'b0111) begin n_fail++; $display("FAIL resume_tick cols %h val %b exp 82e/0111", ba.slot_col[11:0], ba.slot_valid); end
    endtask

    task automatic test_collide();
        logic [15:0] col_s;
        logic [3:0]  val_s;
        col_s = ba.slot_col; val_s = ba.slot_valid;
        @(negedge clk) begin ba.collide = 1'b1; ba.scroll_tick = 1'b1; end
        @(negedge clk) begin ba.collide = 1'b0; ba.scroll_tick = 1'b0; end
        n_checks++; if (ba.state !== 2'b11 || ba.game_over !== 1'b1 || ba.div_pause !== 1'b1) begin n_fail++; $display("FAIL collide_over state %b go %b div %b exp 11/1/1", ba.state, ba.game_over, ba.div_pause); end
        n_checks++; if (ba.slot_col !== col_s || ba.slot_valid !== val_s || ba.score !== 8'd1) begin n_fail++; $display("FAIL collide_tick_dropped col %h val %b sc %0d exp %h/%b/1", ba.slot_col, ba.slot_valid, ba.score, col_s, val_s); end
        tick_a();
        n_checks++; if (ba.slot_col !== col_s || ba.score !== 8'd1) begin n_fail++; $display("FAIL over_tick_ignored col %h sc %0d", ba.slot_col, ba.score); end
        @(negedge clk) ba.start = 1'b1;
        @(negedge clk) ba.start = 1'b0;
        n_checks++; if (ba.state !== 2'b00 || ba.score !== 8'd0 || ba.slot_valid !== 4'b0000 || ba.game_over !== 1'b0) begin n_fail++; $display("FAIL over_ack state %b sc %0d val %b go %b exp 00/0/0000/0", ba.state, ba.score, ba.slot_valid, ba.game_over); end
    endtask

    task automatic test_async_reset();
        @(negedge clk) ba.start = 1'b1;
        @(negedge clk) ba.start = 1'b0;
        for (int k = 1; k <= 6; k++) tick_a();
        n_checks++; if (ba.slot_valid !== 4'b0001 || ba.state !== 2'b01) begin n_fail++; $display("FAIL rerun_spawn val %b state %b exp 0001/01", ba.slot_valid, ba.state); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (ba.state !== 2'b00 || ba.div_pause !== 1'b1 || ba.slot_valid !== 4'b0000 || ba.slot_col !== 16'h0000) begin n_fail++; $display("FAIL async_reset state %b div %b val %b col %h", ba.state, ba.div_pause, ba.slot_valid, ba.slot_col); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk) ba.start = 1'b1;
        @(negedge clk) ba.start = 1'b0;
        n_checks++; if (ba.state !== 2'b01) begin n_fail++; $display("FAIL post_reset_start got %b exp 01", ba.state); end
    endtask

    task automatic test_small_pool();
        @(negedge clk) bb.start = 1'b1;
        @(negedge clk) bb.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk) bb.scroll_tick = 1'b1;
            @(negedge clk) bb.scroll_tick = 1'b0;
            if ((^bb.slot_col === 1'bx) || (^bb.slot_gap === 1'bx) || (^bb.slot_valid === 1'bx)) begin
                n_checks++; n_fail++; $display("FAIL small_x tick %0d col %h gap %h val %b", k, bb.slot_col, bb.slot_gap, bb.slot_valid);
            end
            if (k == 4) begin
                n_checks++; if (bb.slot_valid !== 2'b11 || bb.slot_col !== 8'hFD) begin n_fail++; $display("FAIL small_t4 val %b col %h exp 11/fd", bb.slot_valid, bb.slot_col); end
            end
            if (k == 6) begin
                n_checks++; if (bb.slot_col !== 8'hDB) begin n_fail++; $display("FAIL small_t6_drop col %h exp db", bb.slot_col); end
            end
            if (k == 18) begin
                n_checks++; if (bb.slot_valid !== 2'b10 || bb.score !== 8'd1) begin n_fail++; $display("FAIL small_t18 val %b sc %0d exp 10/1", bb.slot_valid, bb.score); end
            end
            if (k == 20) begin
                n_checks++; if (bb.slot_valid !== 2'b01 || bb.score !== 8'd2 || bb.slot_col[3:0] !== 4'd15) begin n_fail++; $display("FAIL small_t20 val %b sc %0d col0 %0d exp 01/2/15", bb.slot_valid, bb.score, bb.slot_col[3:0]); end
            end
            if (k == 36) begin
                n_checks++; if (bb.slot_valid !== 2'b10 || bb.score !== 8'd3) begin n_fail++; $display("FAIL small_t36 val %b sc %0d exp 10/3", bb.slot_valid, bb.score); end
            end
        end
        n_checks++; if (bb.slot_valid !== 2'b11 || bb.score !== 8'd4 || bb.slot_col !== 8'hFD) begin n_fail++; $display("FAIL small_t40 val %b sc %0d col %h exp 11/4/fd", bb.slot_valid, bb.score, bb.slot_col); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ba.start = 1'b0; ba.pause = 1'b0; ba.collide = 1'b0; ba.scroll_tick = 1'b0;
        bb.start = 1'b0; bb.pause = 1'b0; bb.collide = 1'b0; bb.scroll_tick = 1'b0;
        test_reset();
        test_start();
        test_first_spawn();
        test_scroll_retire();
        test_pause();
        test_collide();
        test_async_reset();
        test_small_pool();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
